// File: rtl/riscv_bitops_unit.sv
// Iterative execution unit for the custom bit-operation instructions (bit count, bit reverse).
// Processes CHUNK operand bits per cycle and returns the result over a valid/ready handshake.
module riscv_bitops_unit #(
    parameter int                          CHUNK           = 8,
    parameter int                          BIT_OP_WIDTH    = 2,
    parameter logic [BIT_OP_WIDTH-1:0]     BIT_OP_BITCOUNT = BIT_OP_WIDTH'(0),
    parameter logic [BIT_OP_WIDTH-1:0]     BIT_OP_REVERSE  = BIT_OP_WIDTH'(1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [BIT_OP_WIDTH-1:0] operator_i,
    input  logic [31:0]             operand_i,
    output logic                    ready_o,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [31:0]             result_o,
    input  logic                    result_ready_i
);

    // state | meaning
    // IDLE  | waiting for a request, ready_o high
    // BUSY  | consuming CHUNK operand bits per cycle
    // DONE  | result presented on result_o until result_ready_i

    localparam int N  = 32 / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [31:0]     shift_q;
    logic [31:0]     rev_q;
    logic [5:0]      acc_q;
    logic [CW-1:0]   cnt_q;
    logic            is_rev_q;

    logic [CHUNK-1:0] chunk;
    logic [CHUNK-1:0] chunk_rev;
    logic [5:0]       chunk_pop;
    logic [31:0]      rev_next;
    logic [5:0]       acc_next;
    logic             last_iter;

    always_comb begin
        chunk     = shift_q[CHUNK-1:0];
        chunk_pop = '0;
        chunk_rev = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop    = chunk_pop + 6'(chunk[i]);
            chunk_rev[i] = chunk[CHUNK-1-i];
        end
        // Earlier (low-order) chunks are pushed toward the MSB end as later chunks enter at the LSB end.
        rev_next  = (rev_q << CHUNK) | 32'(chunk_rev);
        acc_next  = acc_q + chunk_pop;
        last_iter = (cnt_q == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            shift_q  <= '0;
            rev_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            is_rev_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        shift_q  <= operand_i;
                        rev_q    <= '0;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        is_rev_q <= (operator_i == BIT_OP_REVERSE);
                        ready_o  <= 1'b0;
                        if (operator_i == BIT_OP_BITCOUNT || operator_i == BIT_OP_REVERSE) begin
                            state_q <= BUSY;
                            busy_o  <= 1'b1;
                        end else begin
                            state_q  <= DONE;
                            valid_o  <= 1'b1;
                            result_o <= '0;
                        end
                    end
                end
                BUSY: begin
                    shift_q <= shift_q >> CHUNK;
                    rev_q   <= rev_next;
                    acc_q   <= acc_next;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_iter) begin
                        state_q  <= DONE;
                        busy_o   <= 1'b0;
                        valid_o  <= 1'b1;
                        result_o <= is_rev_q ? rev_next : {26'd0, acc_next};
                    end
                end
                DONE: begin
                    if (result_ready_i) begin
                        state_q  <= IDLE;
                        valid_o  <= 1'b0;
                        ready_o  <= 1'b1;
                        result_o <= '0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ready_o  <= 1'b1;
                    busy_o   <= 1'b0;
                    valid_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_bitops_unit.sv
// Scoreboard bench for riscv_bitops_unit: three instances (CHUNK 8, 1, 32) each with
// their own directed driver and a monitor that pops expected results when valid_o rises.
module tb_riscv_bitops_unit;

    localparam logic [1:0] OP_BC  = 2'd0;
    localparam logic [1:0] OP_REV = 2'd1;
    localparam logic [1:0] OP_BAD = 2'd3;

    localparam logic [1:0]  VOP [7] = '{OP_BC, OP_BC, OP_BC, OP_REV, OP_REV, OP_REV, OP_BAD};
    localparam logic [31:0] VA  [7] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001,
                                        32'h0000_0001, 32'h1234_5678, 32'hFFFF_0000, 32'hFFFF_FFFF};
    localparam logic [31:0] VE  [7] = '{32'h0000_0020, 32'h0000_0000, 32'h0000_0002,
                                        32'h8000_0000, 32'h1E6A_2C48, 32'h0000_FFFF, 32'h0000_0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    function automatic void chk(string tag, int chunk, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [CHUNK=%0d] got 0x%08h expected 0x%08h", tag, chunk, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_unit
        localparam int C = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
        localparam int N = 32 / C;

        logic        rst, enable, ready, busy, valid, result_ready;
        logic [1:0]  op;
        logic [31:0] operand, result;
        logic [31:0] exp_q [$];
        logic        prev_valid  = 1'b0;
        logic [31:0] prev_result = '0;

        riscv_bitops_unit #(.CHUNK(C)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .enable_i       (enable),
            .operator_i     (op),
            .operand_i      (operand),
            .ready_o        (ready),
            .busy_o         (busy),
            .valid_o        (valid),
            .result_o       (result),
            .result_ready_i (result_ready)
        );

        always @(negedge clk) begin
            chk("onehot_state", C, 32'($countones({ready, busy, valid})), 32'd1);
            if (!valid) begin
                chk("result_zero_when_invalid", C, result, 32'h0);
            end else if (prev_valid) begin
                chk("result_stable", C, result, prev_result);
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result [CHUNK=%0d] got 0x%08h expected none", C, result);
            end else begin
                chk("result", C, result, exp_q.pop_front());
            end
            prev_valid  = valid;
            prev_result = result;
        end

        task automatic wait_ready();
            int t = 0;
            while (!ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("ready_wait", C, 32'(ready), 32'd1);
        endtask

        task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] e,
                             input int lat);
            int nb = 0;
            int t  = 0;
            wait_ready();
            enable  = 1'b1;
            op      = o;
            operand = a;
            exp_q.push_back(e);
            @(negedge clk);
            enable  = 1'b0;
            operand = ~a;
            while (!valid && t < 100) begin
                if (busy) nb++;
                t++;
                @(negedge clk);
            end
            chk("busy_cycles", C, 32'(nb), 32'(lat));
            chk("valid_seen", C, 32'(valid), 32'd1);
        endtask

        initial begin
            int t;
            rst          = 1'b1;
            enable       = 1'b0;
            op           = OP_BC;
            operand      = '0;
            result_ready = 1'b1;
            repeat (2) @(negedge clk);
            chk("reset_ready", C, 32'(ready), 32'd1);
            chk("reset_busy",  C, 32'(busy),  32'd0);
            chk("reset_valid", C, 32'(valid), 32'd0);
            chk("reset_result", C, result, 32'h0);
            rst = 1'b0;
            @(negedge clk);

            for (int i = 0; i < 7; i++) begin
                issue(VOP[i], VA[i], VE[i], (VOP[i] == OP_BAD) ? 0 : N);
                @(negedge clk);
                chk("ready_after_result", C, 32'(ready), 32'd1);
            end

            // backpressure: hold the result for 10 cycles
            result_ready = 1'b0;
            issue(OP_REV, 32'h0000_000F, 32'hF000_0000, N);
            repeat (10) begin
                @(negedge clk);
                chk("bp_valid_held", C, 32'(valid), 32'd1);
            end
            result_ready = 1'b1;
            @(negedge clk);
            chk("bp_release_ready", C, 32'(ready), 32'd1);
            chk("bp_release_result", C, result, 32'h0);

            // enable held with changing inputs during BUSY and DONE
            wait_ready();
            enable       = 1'b1;
            op           = OP_BC;
            operand      = 32'h0000_00FF;
            exp_q.push_back(32'd8);
            @(negedge clk);
            result_ready = 1'b0;
            t = 0;
            while (!valid && t < 100) begin
                operand = operand + 32'h1111_1111;
                op      = t[0] ? OP_REV : OP_BAD;
                t++;
                @(negedge clk);
            end
            chk("hold_valid_seen", C, 32'(valid), 32'd1);
            repeat (3) begin
                operand = operand + 32'h1111_1111;
                @(negedge clk);
            end
            op           = OP_BC;
            operand      = 32'h0000_0003;
            exp_q.push_back(32'd2);
            result_ready = 1'b1;
            @(negedge clk);
            chk("hold_ready_after_consume", C, 32'(ready), 32'd1);
            @(negedge clk);
            enable = 1'b0;
            chk("hold_second_accept_busy", C, 32'(busy), 32'd1);
            t = 0;
            while (!valid && t < 100) begin
                t++;
                @(negedge clk);
            end
            chk("hold_second_valid", C, 32'(valid), 32'd1);
            @(negedge clk);

            // reset in the middle of a bit count
            wait_ready();
            enable  = 1'b1;
            op      = OP_BC;
            operand = 32'hFFFF_FFFF;
            @(negedge clk);
            enable = 1'b0;
            chk("midrst_busy_before", C, 32'(busy), 32'd1);
            rst = 1'b1;
            @(negedge clk);
            chk("midrst_ready", C, 32'(ready), 32'd1);
            chk("midrst_busy",  C, 32'(busy),  32'd0);
            chk("midrst_valid", C, 32'(valid), 32'd0);
            chk("midrst_result", C, result, 32'h0);
            rst = 1'b0;
            @(negedge clk);
            issue(OP_BC, 32'h0000_000F, 32'd4, N);
            @(negedge clk);
            chk("final_ready", C, 32'(ready), 32'd1);
            repeat (3) @(negedge clk);
            chk("queue_drained", C, 32'(exp_q.size()), 32'd0);
            done_cnt++;
        end
    end

    initial begin
        int cyc = 0;
        while (done_cnt < 3 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        n_checks++;
        if (done_cnt < 3) begin
            n_fail++;
            $display("FAIL timeout got %0d finished units expected 3", done_cnt);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
